// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase instruction sequencer for the 8-bit RISC CPU
// Fetch in phases 0-3, execute in 4-7; HLT freezes the sequencer at phase 4 until reset.
module cpu_controller #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           data_e,
  output logic           ld_ac,
  output logic           halt,
  output logic [2:0]     phase
);

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  logic halted;
  logic is_hlt;
  logic is_sto;
  logic is_jmp;
  logic alu_op;

  assign is_hlt = (opcode == OP_HLT);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Leaving OP_ADDR on HLT latches halted and keeps phase parked at 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (phase == OP_ADDR && is_hlt) begin
        halted <= 1'b1;
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    halt   = halted;
    if (!halted) begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
          ld_ir  = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = !is_hlt;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          mem_rd = alu_op;
        end
        ALU_OP: begin
          // SKZ skip is the second PC increment of the instruction.
          mem_rd = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          mem_rd = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          mem_wr = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule
